// File: rtl/gptp_pkg.sv
// Shared definitions for the gPTP receive path: message types, field byte
// offsets within the Layer-2 frame and bit positions inside the packed frame word.
package gptp_pkg;

    localparam logic [3:0] MSG_SYNC           = 4'h0;
    localparam logic [3:0] MSG_PDELAY_REQ     = 4'h2;
    localparam logic [3:0] MSG_PDELAY_RESP    = 4'h3;
    localparam logic [3:0] MSG_FOLLOW_UP      = 4'h8;
    localparam logic [3:0] MSG_PDELAY_RESP_FU = 4'hA;

    localparam logic [6:0] OFF_ETYPE_HI = 7'd12;
    localparam logic [6:0] OFF_ETYPE_LO = 7'd13;
    localparam logic [6:0] OFF_MSG_TYPE = 7'd14;
    localparam logic [6:0] OFF_VERSION  = 7'd15;
    localparam logic [6:0] OFF_DOMAIN   = 7'd18;
    localparam logic [6:0] OFF_FLAGS    = 7'd20;
    localparam logic [6:0] OFF_CORR     = 7'd22;
    localparam logic [6:0] OFF_SRC_PORT = 7'd34;
    localparam logic [6:0] OFF_SEQ      = 7'd44;
    localparam logic [6:0] OFF_BODY_TS  = 7'd48;
    localparam logic [6:0] OFF_REQ_PORT = 7'd58;

    // Offset of the final byte a frame must reach (length - 1).
    localparam logic [6:0] LAST_SHORT = 7'd57;
    localparam logic [6:0] LAST_LONG  = 7'd67;

    localparam int WORD_W       = 432;
    localparam int POS_RX_TS    = 431;
    localparam int POS_REQ_PORT = 347;
    localparam int POS_FLAGS    = 267;
    localparam int POS_DOMAIN   = 251;
    localparam int POS_CORR     = 243;
    localparam int POS_SRC_PORT = 179;
    localparam int POS_SEQ      = 99;
    localparam int POS_MSG_TYPE = 83;
    localparam int POS_BODY_TS  = 79;

    typedef struct packed {
        logic [47:0] sec;
        logic [31:0] ns;
    } ptp_ts_t;

    function automatic logic msg_type_ok(input logic [3:0] t);
        return (t == MSG_SYNC) || (t == MSG_PDELAY_REQ) || (t == MSG_PDELAY_RESP) ||
               (t == MSG_FOLLOW_UP) || (t == MSG_PDELAY_RESP_FU);
    endfunction

    function automatic logic has_req_port(input logic [3:0] t);
        return (t == MSG_PDELAY_RESP) || (t == MSG_PDELAY_RESP_FU);
    endfunction

    function automatic logic in_field(input logic [6:0] off, input logic [6:0] lo,
                                      input logic [6:0] n);
        return (off >= lo) && (off < lo + n);
    endfunction

endpackage

// File: rtl/gptp_rx_parser.sv
// Filters Layer-2 gPTP frames from the MAC byte stream and publishes one packed
// frame word per accepted frame through a single-entry valid/ready output.
//
// state | meaning
// IDLE  | waiting for a byte qualified by rx_sof
// CAPT  | frame passes filters so far, bytes stored by offset
// SKIP  | frame rejected by a filter, discarding until rx_last
module gptp_rx_parser
    import gptp_pkg::*;
#(
    parameter logic [15:0] ETHERTYPE   = 16'h88F7,
    parameter logic [3:0]  SDO_ID      = 4'h1,
    parameter logic [3:0]  PTP_VERSION = 4'h2,
    parameter logic [7:0]  DOMAIN      = 8'h00
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    input  logic               rx_sof,
    input  logic               rx_last,
    input  logic               rx_err,
    input  logic [79:0]        rx_ts,
    output logic [WORD_W-1:0]  gptp_rv_data,
    output logic               gptp_rv_vaild,
    input  logic               gptp_rv_ready,
    output logic [15:0]        drop_cnt
);

    typedef enum logic [1:0] {IDLE, CAPT, SKIP} state_t;

    state_t      state;
    logic [6:0]  byte_cnt;
    ptp_ts_t     ts_lat;
    logic [7:0]  etype_hi, etype_hi_nxt;
    logic [3:0]  msg_type, msg_type_nxt;
    logic [7:0]  domain, domain_nxt;
    logic [15:0] flags, flags_nxt;
    logic [63:0] corr, corr_nxt;
    logic [79:0] src_port, src_port_nxt;
    logic [15:0] seq, seq_nxt;
    logic [79:0] body_ts, body_ts_nxt;
    logic [79:0] req_port, req_port_nxt;

    logic              capt, filt_fail, long_frame, len_ok, slot_free;
    logic              frame_done, publish, drop;
    logic [WORD_W-1:0] word;

    // byte_cnt holds the offset of the byte currently on rx_data while in CAPT.
    always_comb begin
        capt         = rx_valid && !rx_sof && (state == CAPT);
        etype_hi_nxt = etype_hi;
        msg_type_nxt = msg_type;
        domain_nxt   = domain;
        flags_nxt    = flags;
        corr_nxt     = corr;
        src_port_nxt = src_port;
        seq_nxt      = seq;
        body_ts_nxt  = body_ts;
        req_port_nxt = req_port;
        if (capt) begin
            if (byte_cnt == OFF_ETYPE_HI) etype_hi_nxt = rx_data;
            if (byte_cnt == OFF_MSG_TYPE) msg_type_nxt = rx_data[3:0];
            if (byte_cnt == OFF_DOMAIN)   domain_nxt   = rx_data;
            if (in_field(byte_cnt, OFF_FLAGS, 7'd2))     flags_nxt    = {flags[7:0], rx_data};
            if (in_field(byte_cnt, OFF_CORR, 7'd8))      corr_nxt     = {corr[55:0], rx_data};
            if (in_field(byte_cnt, OFF_SRC_PORT, 7'd10)) src_port_nxt = {src_port[71:0], rx_data};
            if (in_field(byte_cnt, OFF_SEQ, 7'd2))       seq_nxt      = {seq[7:0], rx_data};
            if (in_field(byte_cnt, OFF_BODY_TS, 7'd10))  body_ts_nxt  = {body_ts[71:0], rx_data};
            if (in_field(byte_cnt, OFF_REQ_PORT, 7'd10)) req_port_nxt = {req_port[71:0], rx_data};
        end

        filt_fail = capt && (
            ((byte_cnt == OFF_ETYPE_LO) && ({etype_hi, rx_data} != ETHERTYPE)) ||
            ((byte_cnt == OFF_MSG_TYPE) &&
                ((rx_data[7:4] != SDO_ID) || !msg_type_ok(rx_data[3:0]))) ||
            ((byte_cnt == OFF_VERSION) && (rx_data[3:0] != PTP_VERSION)) ||
            ((byte_cnt == OFF_DOMAIN) && (rx_data != DOMAIN)));

        long_frame = has_req_port(msg_type_nxt);
        len_ok     = byte_cnt >= (long_frame ? LAST_LONG : LAST_SHORT);
        slot_free  = !gptp_rv_vaild || gptp_rv_ready;
        frame_done = capt && rx_last && !filt_fail;
        publish    = frame_done && len_ok && !rx_err && slot_free;
        drop       = (rx_valid && rx_sof && (state == CAPT)) || (frame_done && !publish);

        word = '0;
        word[POS_RX_TS    -: 80] = ts_lat;
        word[POS_REQ_PORT -: 80] = long_frame ? req_port_nxt : 80'h0;
        word[POS_FLAGS    -: 16] = flags_nxt;
        word[POS_DOMAIN   -: 8]  = domain_nxt;
        word[POS_CORR     -: 64] = corr_nxt;
        word[POS_SRC_PORT -: 80] = src_port_nxt;
        word[POS_SEQ      -: 16] = seq_nxt;
        word[POS_MSG_TYPE -: 4]  = msg_type_nxt;
        word[POS_BODY_TS  -: 80] = body_ts_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            byte_cnt      <= '0;
            ts_lat        <= '0;
            etype_hi      <= '0;
            msg_type      <= '0;
            domain        <= '0;
            flags         <= '0;
            corr          <= '0;
            src_port      <= '0;
            seq           <= '0;
            body_ts       <= '0;
            req_port      <= '0;
            gptp_rv_data  <= '0;
            gptp_rv_vaild <= 1'b0;
            drop_cnt      <= '0;
        end else begin
            etype_hi <= etype_hi_nxt;
            msg_type <= msg_type_nxt;
            domain   <= domain_nxt;
            flags    <= flags_nxt;
            corr     <= corr_nxt;
            src_port <= src_port_nxt;
            seq      <= seq_nxt;
            body_ts  <= body_ts_nxt;
            req_port <= req_port_nxt;

            if (gptp_rv_vaild && gptp_rv_ready) gptp_rv_vaild <= 1'b0;
            if (publish) begin
                gptp_rv_data  <= word;
                gptp_rv_vaild <= 1'b1;
            end
            if (drop && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;

            if (rx_valid) begin
                if (byte_cnt != 7'd127) byte_cnt <= byte_cnt + 7'd1;
                if (rx_sof) begin
                    byte_cnt <= 7'd1;
                    ts_lat   <= rx_ts;
                    state    <= rx_last ? IDLE : CAPT;
                end else begin
                    case (state)
                        CAPT: begin
                            if (rx_last)        state <= IDLE;
                            else if (filt_fail) state <= SKIP;
                        end
                        SKIP: if (rx_last) state <= IDLE;
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_gptp_rx_parser.sv
// Directed-frame bench for gptp_rx_parser with a queue-based scoreboard and an
// independent output monitor.
module tb_gptp_rx_parser;

    localparam logic [15:0] FLAGS = 16'h0208;
    localparam logic [63:0] CORR  = 64'h0000_0000_0123_4000;
    localparam logic [79:0] SRC   = 80'h0011_2233_4455_6677_0001;
    localparam logic [79:0] REQ   = 80'hAABB_CCDD_EEFF_0011_0002;

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   rx_data;
    logic         rx_valid, rx_sof, rx_last, rx_err;
    logic [79:0]  rx_ts;
    logic [431:0] gptp_rv_data;
    logic         gptp_rv_vaild;
    logic         gptp_rv_ready;
    logic [15:0]  drop_cnt;

    always #5 clk = ~clk;

    gptp_rx_parser dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_sof(rx_sof), .rx_last(rx_last), .rx_err(rx_err), .rx_ts(rx_ts),
        .gptp_rv_data(gptp_rv_data), .gptp_rv_vaild(gptp_rv_vaild),
        .gptp_rv_ready(gptp_rv_ready), .drop_cnt(drop_cnt)
    );

    logic [7:0]   fr [0:127];
    logic [431:0] exp_q [$];
    int           n_vec = 0;
    int           n_err = 0;
    int           exp_drop = 0;

    task automatic check(input string name, input logic [431:0] act, input logic [431:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic put(input int off, input int n, input logic [79:0] v);
        for (int k = 0; k < n; k++) fr[off + k] = v[8 * (n - 1 - k) +: 8];
    endtask

    task automatic build(input logic [3:0] mt, input logic [15:0] et, input logic [7:0] dom,
                         input logic [79:0] body, input logic [15:0] seq);
        for (int i = 0; i < 128; i++) fr[i] = 8'(i);
        put(12, 2, {64'h0, et});
        fr[14] = {4'h1, mt};
        fr[15] = 8'h02;
        fr[18] = dom;
        put(20, 2, {64'h0, FLAGS});
        put(22, 8, {16'h0, CORR});
        put(34, 10, SRC);
        put(44, 2, {64'h0, seq});
        put(48, 10, body);
        put(58, 10, REQ);
    endtask

    function automatic logic [431:0] expw(input logic [79:0] ts, input logic [3:0] mt,
                                          input logic [79:0] body, input logic [15:0] seq,
                                          input bit with_req);
        return {ts, 4'h0, (with_req ? REQ : 80'h0), FLAGS, 8'h00, CORR, SRC, seq, mt, body};
    endfunction

    task automatic send_range(input int lo, input int hi, input logic [79:0] ts,
                              input bit last, input bit err);
        for (int i = lo; i <= hi; i++) begin
            rx_valid = 1'b1;
            rx_data  = fr[i];
            rx_sof   = (i == 0);
            rx_last  = last && (i == hi);
            rx_err   = err && (i == hi);
            rx_ts    = ts;
            @(posedge clk); #1;
        end
        rx_valid = 1'b0; rx_sof = 1'b0; rx_last = 1'b0; rx_err = 1'b0; rx_data = 8'h0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Monitor: pops the scoreboard on every handshake and checks hold stability.
    logic         held = 1'b0;
    logic [431:0] held_data;
    always @(negedge clk) begin
        if (reset) begin
            held = 1'b0;
        end else if (gptp_rv_vaild) begin
            if (held) check("hold_stable", gptp_rv_data, held_data);
            if (gptp_rv_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_word: got %0h, required no word", gptp_rv_data);
                end else begin
                    check("word", gptp_rv_data, exp_q.pop_front());
                end
                held = 1'b0;
            end else begin
                held      = 1'b1;
                held_data = gptp_rv_data;
            end
        end else if (held) begin
            n_vec++; n_err++;
            $display("FAIL vaild_dropped_unaccepted: got vaild=0, required vaild=1");
            held = 1'b0;
        end
    end

    initial begin
        reset = 1'b1; rx_valid = 1'b0; rx_sof = 1'b0; rx_last = 1'b0; rx_err = 1'b0;
        rx_data = 8'h0; rx_ts = 80'h0; gptp_rv_ready = 1'b0;
        repeat (3) @(posedge clk); #1;
        reset = 1'b0;
        idle(1);
        check("rst_vaild", gptp_rv_vaild, 0);
        check("rst_data", gptp_rv_data, 0);
        check("rst_drop", drop_cnt, 0);

        // Pdelay_Resp, 68 bytes
        gptp_rv_ready = 1'b1;
        build(4'h3, 16'h88F7, 8'h00, 80'h123456789abc00000001, 16'h0005);
        exp_q.push_back(expw(80'h123456789abc00000002, 4'h3, 80'h123456789abc00000001, 16'h0005, 1));
        send_range(0, 67, 80'h123456789abc00000002, 1, 0);
        check("pdresp_latency", gptp_rv_vaild, 1);
        idle(3);
        check("pdresp_accepted", gptp_rv_vaild, 0);

        // Filter rejects are silent
        build(4'h0, 16'h0800, 8'h00, 80'h1, 16'h0001);
        send_range(0, 57, 80'h11, 1, 0);
        check("etype_reject", gptp_rv_vaild, 0);
        build(4'h0, 16'h88F7, 8'h01, 80'h1, 16'h0002);
        send_range(0, 57, 80'h12, 1, 0);
        check("domain_reject", gptp_rv_vaild, 0);
        idle(2);
        check("reject_no_drop", drop_cnt, 16'(exp_drop));

        // Busy output: second Follow_Up dropped; requestingPortIdentity forced to zero
        gptp_rv_ready = 1'b0;
        build(4'h8, 16'h88F7, 8'h00, 80'h0000_0000_0010_0000_0200, 16'h0007);
        exp_q.push_back(expw(80'h21, 4'h8, 80'h0000_0000_0010_0000_0200, 16'h0007, 0));
        send_range(0, 57, 80'h21, 1, 0);
        check("fu_publish", gptp_rv_vaild, 1);
        idle(2);
        build(4'h8, 16'h88F7, 8'h00, 80'h0000_0000_0011_0000_0300, 16'h0008);
        send_range(0, 57, 80'h22, 1, 0);
        exp_drop++;
        check("busy_drop", drop_cnt, 16'(exp_drop));
        idle(4);
        gptp_rv_ready = 1'b1;
        idle(1);
        check("ready_release", gptp_rv_vaild, 0);

        // Short frames and rx_err
        build(4'hA, 16'h88F7, 8'h00, 80'h5, 16'h0009);
        send_range(0, 60, 80'h31, 1, 0);
        exp_drop++;
        check("short_pdfu_drop", drop_cnt, 16'(exp_drop));
        build(4'h0, 16'h88F7, 8'h00, 80'h6, 16'h000A);
        send_range(0, 57, 80'h32, 1, 1);
        exp_drop++;
        check("err_drop", drop_cnt, 16'(exp_drop));
        send_range(0, 56, 80'h33, 1, 0);
        exp_drop++;
        check("len57_drop", drop_cnt, 16'(exp_drop));
        check("short_no_publish", gptp_rv_vaild, 0);

        // sof abort mid-frame, then a complete Sync
        build(4'h0, 16'h88F7, 8'h00, 80'h0000_0000_0042_0000_0777, 16'h0021);
        send_range(0, 29, 80'h41, 0, 0);
        exp_q.push_back(expw(80'h42, 4'h0, 80'h0000_0000_0042_0000_0777, 16'h0021, 0));
        send_range(0, 57, 80'h42, 1, 0);
        exp_drop++;
        check("sof_abort_drop", drop_cnt, 16'(exp_drop));
        check("sof_abort_publish", gptp_rv_vaild, 1);
        idle(3);

        // Back-to-back: accept and new publish on the same edge
        gptp_rv_ready = 1'b0;
        build(4'h0, 16'h88F7, 8'h00, 80'h51, 16'h0031);
        exp_q.push_back(expw(80'h50, 4'h0, 80'h51, 16'h0031, 0));
        send_range(0, 57, 80'h50, 1, 0);
        idle(2);
        build(4'h3, 16'h88F7, 8'h00, 80'h61, 16'h0032);
        exp_q.push_back(expw(80'h60, 4'h3, 80'h61, 16'h0032, 1));
        send_range(0, 66, 80'h60, 0, 0);
        gptp_rv_ready = 1'b1;
        send_range(67, 67, 80'h60, 1, 0);
        check("b2b_vaild", gptp_rv_vaild, 1);
        check("b2b_no_drop", drop_cnt, 16'(exp_drop));
        idle(3);

        // Reset mid-frame
        build(4'h0, 16'h88F7, 8'h00, 80'h71, 16'h0041);
        send_range(0, 39, 80'h70, 0, 0);
        reset = 1'b1;
        send_range(40, 40, 80'h70, 0, 0);
        reset = 1'b0;
        send_range(41, 57, 80'h70, 1, 0);
        exp_drop = 0;
        check("midreset_drop", drop_cnt, 16'(exp_drop));
        check("midreset_vaild", gptp_rv_vaild, 0);
        build(4'h0, 16'h88F7, 8'h00, 80'h81, 16'h0042);
        exp_q.push_back(expw(80'h80, 4'h0, 80'h81, 16'h0042, 0));
        send_range(0, 57, 80'h80, 1, 0);
        check("post_reset_publish", gptp_rv_vaild, 1);
        idle(4);

        check("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gptp_rx_parser.md
Name: gptp_rx_parser

Overview:
- Upstream neighbour of the rx gPTP logic stage.
- Consumes the MAC receive byte stream of Layer-2 gPTP frames (EtherType 0x88F7) plus the receive timestamp captured at start of frame.
- Filters and extracts the fields the logic stage needs, then publishes one 432-bit frame word per accepted frame on a valid/ready handshake.
- Has a single output register and no buffering: a frame that completes while the output is occupied is dropped and counted.

Parameters:
- ETHERTYPE, 16'h88F7, required EtherType at bytes 12-13.
- SDO_ID, 4'h1, required majorSdoId (byte 14 high nibble).
- PTP_VERSION, 4'h2, required versionPTP (byte 15 low nibble).
- DOMAIN, 8'h00, required domainNumber (byte 18).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- rx_data  in  8  frame byte; byte 0 is the first destination-MAC byte
- rx_valid  in  1  rx_data valid; no backpressure
- rx_sof  in  1  qualifies the first byte of a frame
- rx_last  in  1  qualifies the last byte of a frame
- rx_err  in  1  frame error (FCS/PHY); sampled with rx_last
- rx_ts  in  80  receive timestamp {sec[47:0], ns[31:0]}; sampled on the sof byte
- gptp_rv_data  out  432  packed frame word
- gptp_rv_vaild  out  1  gptp_rv_data holds a frame
- gptp_rv_ready  in  1  downstream accepts the word
- drop_cnt  out  16  saturating count of lost frames

Behaviour:
- Reset: state=IDLE; gptp_rv_vaild=0; gptp_rv_data=0; drop_cnt=0; byte counter=0. Reset mid-frame discards that frame without counting it; the next frame is recognised only by rx_sof.

Packing of gptp_rv_data (all fields big-endian, first received byte at the MSB):
- [431:352] rx_ts
- [351:348] 4'h0
- [347:268] requestingPortIdentity, bytes 58-67
- [267:252] flags, bytes 20-21
- [251:244] domain, byte 18
- [243:180] correctionField, bytes 22-29
- [179:100] sourcePortIdentity, bytes 34-43
- [99:84] sequenceId, bytes 44-45
- [83:80] messageType, byte 14 low nibble
- [79:0] body timestamp, bytes 48-57

Byte counter:
- 7 bits; 0 on the sof byte; increments per valid byte; saturates at 127.

FSM:
- IDLE: on rx_valid & rx_sof, latch rx_ts, capture byte 0, go to CAPT.
- CAPT: store bytes into the capture register by offset. At the byte that completes a filter field, check it; on mismatch go to SKIP. Filters:
  - EtherType == ETHERTYPE
  - SDO_ID
  - PTP_VERSION
  - DOMAIN
  - messageType in {0x0, 0x2, 0x3, 0x8, 0xA}
- Required length: 58 bytes; 68 bytes for messageType 0x3 and 0xA. For the other types, requestingPortIdentity is forced to 0.
- CAPT on rx_last:
  - If length is met and rx_err=0, publish.
  - Otherwise drop, counted.
- SKIP: discard bytes until rx_last, then go to IDLE. Filter rejects are not counted.
- rx_sof in CAPT or SKIP aborts the current frame (counted only if in CAPT) and restarts capture from this byte.
- rx_sof & rx_last on the same byte: 1-byte frame; treated as short (counted only if it had reached CAPT, which it never does), so the result is: ignored.

Publish:
- The output slot is free if gptp_rv_vaild=0, or if gptp_rv_vaild & gptp_rv_ready in the same cycle.
- If free: gptp_rv_data updates and gptp_rv_vaild=1 on the edge after the rx_last byte (1-cycle latency).
- If not free: the frame is dropped and counted.

Handshake:
- gptp_rv_vaild stays high and gptp_rv_data is stable until ready is sampled high.
- Accept and new publish in the same cycle gives back-to-back valid with new data.

drop_cnt:
- Increments by 1 per counted drop, including short, rx_err, busy, and sof-abort.
- Saturates at 16'hFFFF.

Decomposition:
- Shared package gptp_pkg holds:
  - messageType constants (SYNC=4'h0, PDELAY_REQ=4'h2, PDELAY_RESP=4'h3, FOLLOW_UP=4'h8, PDELAY_RESP_FU=4'hA)
  - field byte offsets
  - packed-word bit positions (also used by the logic stage)
  - the 80-bit timestamp type
- No sub-module. Capture register writes and the FSM stay in one file.

Test Plan:
- Pdelay_Resp frame: 68 bytes, rx_ts=80'h123456789abc00000002, body ts 80'h123456789abc00000001, seqId 16'h0005, ready=1. Expect: one cycle after rx_last, vaild=1, [431:352]=...0002, [83:80]=4'h3, [79:0]=...0001, [99:84]=16'h0005.
- Sync frame with EtherType 0x0800, then with domain 8'h01. Expect: vaild never rises; drop_cnt=0.
- Hold ready=0, send two valid Follow_Up frames. Expect: the first is held stable; the second is dropped and drop_cnt=1. Raise ready: vaild falls the next cycle.
- Pdelay_Resp_FU ending at byte 60, and a Sync with rx_err=1 on last. Expect: no publish; drop_cnt=2.
- rx_sof asserted at byte 30 of a Sync, then a complete Sync follows. Expect: drop_cnt=1, and exactly one word, carrying the second frame's rx_ts.
- Assert reset at byte 40 of a Sync, deassert, let the tail bytes complete, then send a full Sync. Expect: only the second frame is published; drop_cnt=0.
